// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   state_t   : FSM state encoding (IDLE, REQ)
//   SIZE_*    : ex_mem_size encodings
//   BE_WORD   : byte-enable pattern for a full word access
package mem_stage_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  localparam logic       SIZE_WORD = 1'b0;
  localparam logic       SIZE_BYTE = 1'b1;
  localparam logic [3:0] BE_WORD   = 4'b1111;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit (purely combinational).
// Ports:
//   size       in  access size (SIZE_WORD / SIZE_BYTE)
//   addr_lo    in  byte offset within the word
//   store_data in  raw store data from the pipeline
//   rdata      in  word returned by data memory
//   be         out byte enables for the access
//   wdata      out store data placed on the memory lanes
//   load_data  out load result, byte loads zero-extended
module lsu_lane_align
  import mem_stage_pkg::*;
(
  input  logic        size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  always_comb begin
    be        = BE_WORD;
    wdata     = store_data;
    load_data = rdata;
    if (size == SIZE_BYTE) begin
      be        = 4'b0001 << addr_lo;
      // replicate so the memory can pick the byte from whichever lane is enabled
      wdata     = {4{store_data[7:0]}};
      load_data = {24'h0, rdata[{addr_lo, 3'b000} +: 8]};
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage with a single-outstanding data-memory handshake.
// Ports:
//   clk, reset                  clock, async active-high reset
//   ex_*                        EX/MEM register contents
//   dm_req/we/addr/wdata/be     data-memory request (registered)
//   dm_ack, dm_rdata            data-memory response
//   stall                       holds EX/MEM and upstream while an access is pending
//   wb_rf_enable/wb_rd/wb_data  MEM/WB register
//   misalign_fault              one-cycle pulse for a misaligned word access
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no access pending; non-memory ops pass straight to MEM/WB
// ST_REQ  | dm_req asserted, waiting for dm_ack; MEM/WB gets bubbles
module mem_stage_lsu
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_load,
  input  logic        ex_mem_write,
  input  logic        ex_mem_size,
  input  logic        ex_mem_enable,
  input  logic        ex_rf_enable,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store_data,
  input  logic [31:0] ex_alu_result,
  input  logic [3:0]  ex_rd,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic        wb_rf_enable,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_fault
);

  state_t      state, state_nxt;
  logic        misaligned;
  logic        is_store;
  logic        issue;
  logic        done;
  logic        size_q;
  logic        rf_en_q;
  logic [3:0]  rd_q;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_ldata;

  assign misaligned = ex_mem_enable && (ex_mem_size == SIZE_WORD) && (ex_addr[1:0] != 2'b00);
  // Store wins when both are set; an enabled op asking for neither is also
  // issued as a write so it can never put junk into the register file.
  assign is_store   = ex_mem_write || !ex_load;

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    issue     = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ex_mem_enable && !misaligned) begin
          issue     = 1'b1;
          stall     = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        stall = !dm_ack;
        if (dm_ack) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dm_req         <= 1'b0;
      dm_we          <= 1'b0;
      size_q         <= SIZE_WORD;
      rf_en_q        <= 1'b0;
      rd_q           <= '0;
      addr_q         <= '0;
      sdata_q        <= '0;
      wb_rf_enable   <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      misalign_fault <= 1'b0;
    end else begin
      misalign_fault <= 1'b0;
      dm_req         <= (state_nxt == ST_REQ);
      if (issue) begin
        dm_we   <= is_store;
        size_q  <= ex_mem_size;
        rf_en_q <= ex_rf_enable;
        rd_q    <= ex_rd;
        addr_q  <= ex_addr;
        sdata_q <= ex_store_data;
      end else if (done) begin
        dm_we <= 1'b0;
      end

      if (state == ST_IDLE) begin
        if (!ex_mem_enable) begin
          wb_data      <= ex_alu_result;
          wb_rd        <= ex_rd;
          wb_rf_enable <= ex_rf_enable;
        end else begin
          wb_rf_enable   <= 1'b0;
          misalign_fault <= misaligned;
        end
      end else if (done) begin
        wb_rd        <= rd_q;
        wb_rf_enable <= dm_we ? 1'b0 : rf_en_q;
        if (!dm_we) wb_data <= lane_ldata;
      end else begin
        wb_rf_enable <= 1'b0;
      end
    end
  end

  lsu_lane_align u_lane (
    .size      (size_q),
    .addr_lo   (addr_q[1:0]),
    .store_data(sdata_q),
    .rdata     (dm_rdata),
    .be        (lane_be),
    .wdata     (lane_wdata),
    .load_data (lane_ldata)
  );

  assign dm_addr  = addr_q;
  assign dm_wdata = lane_wdata;
  assign dm_be    = dm_req ? lane_be : 4'b0000;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_load, ex_mem_write, ex_mem_size, ex_mem_enable, ex_rf_enable;
  logic [31:0] ex_addr, ex_store_data, ex_alu_result;
  logic [3:0]  ex_rd;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        stall, wb_rf_enable, misalign_fault;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;

  mem_stage_lsu dut (
    .clk(clk), .reset(reset),
    .ex_load(ex_load), .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size),
    .ex_mem_enable(ex_mem_enable), .ex_rf_enable(ex_rf_enable),
    .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_alu_result(ex_alu_result),
    .ex_rd(ex_rd),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .stall(stall), .wb_rf_enable(wb_rf_enable), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_fault(misalign_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        mem_en, load, write, size;
    logic [31:0] addr, sdata, alu, rdata;
    logic [3:0]  rd;
    logic        rf_en;
    int          wait_cyc;
    logic        exp_fault;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_we;
    logic        exp_wb_en;
    logic [31:0] exp_wb_data;
  } vec_t;

  typedef struct {
    logic        en;
    logic [3:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t sb[$];
  vec_t    vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    ex_mem_enable = 1'b0; ex_load = 1'b0; ex_mem_write = 1'b0; ex_mem_size = 1'b0;
    ex_rf_enable = 1'b0; ex_addr = '0; ex_store_data = '0; ex_alu_result = '0; ex_rd = '0;
  endtask

  task automatic check_wb(input string tag);
    wb_exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s_sb: no expected entry queued", tag);
    end else begin
      total--;
      e = sb.pop_front();
      chk({tag, "_wb_en"}, wb_rf_enable, e.en);
      if (e.en) begin
        chk({tag, "_wb_data"}, wb_data, e.data);
        chk({tag, "_wb_rd"}, wb_rd, e.rd);
      end
    end
  endtask

  task automatic apply(input vec_t v);
    ex_mem_enable = v.mem_en; ex_load = v.load; ex_mem_write = v.write; ex_mem_size = v.size;
    ex_addr = v.addr; ex_store_data = v.sdata; ex_alu_result = v.alu; ex_rd = v.rd;
    ex_rf_enable = v.rf_en;
    #1;
    if (v.exp_fault) begin
      chk("mis_stall", stall, 1'b0);
      tick;
      chk("mis_pulse", misalign_fault, 1'b1);
      chk("mis_wb_en", wb_rf_enable, 1'b0);
      chk("mis_req", dm_req, 1'b0);
      drive_idle();
      tick;
      chk("mis_clear", misalign_fault, 1'b0);
      chk("mis_req2", dm_req, 1'b0);
    end else if (!v.mem_en) begin
      chk("alu_stall", stall, 1'b0);
      sb.push_back('{v.exp_wb_en, v.rd, v.exp_wb_data});
      tick;
      chk("alu_req", dm_req, 1'b0);
      check_wb("alu");
    end else begin
      chk("issue_stall", stall, 1'b1);
      sb.push_back('{v.exp_wb_en, v.rd, v.exp_wb_data});
      tick;
      chk("req", dm_req, 1'b1);
      chk("req_addr", dm_addr, v.addr);
      chk("req_be", dm_be, v.exp_be);
      chk("req_we", dm_we, v.exp_we);
      if (v.exp_we) chk("req_wdata", dm_wdata, v.exp_wdata);
      for (int w = 0; w < v.wait_cyc; w++) begin
        dm_rdata = $urandom;
        #1;
        chk("wait_stall", stall, 1'b1);
        chk("wait_bubble", wb_rf_enable, 1'b0);
        tick;
        chk("wait_req", dm_req, 1'b1);
        chk("wait_addr", dm_addr, v.addr);
        chk("wait_be", dm_be, v.exp_be);
        if (v.exp_we) chk("wait_wdata", dm_wdata, v.exp_wdata);
      end
      dm_ack = 1'b1;
      dm_rdata = v.rdata;
      drive_idle();
      #1;
      chk("ack_stall", stall, 1'b0);
      tick;
      dm_ack = 1'b0;
      dm_rdata = $urandom;
      chk("done_req", dm_req, 1'b0);
      check_wb("mem");
    end
  endtask

  initial begin
    drive_idle();
    dm_ack = 1'b0;
    dm_rdata = '0;

    // fill vector table: mem,ld,wr,sz, addr, sdata, alu, rdata, rd, rf, wait, fault, be, wdata, we, wb_en, wb_data
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'h1234, 32'h0, 4'd3, 1'b1, 0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h1234};
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 32'h0, 4'd15, 1'b0, 0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1,1'b1,1'b0,1'b0, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 4'd5, 1'b1, 3, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[3]  = '{1'b1,1'b0,1'b1,1'b1, 32'h203, 32'h000000A5, 32'h0, 32'h0, 4'd6, 1'b0, 1, 1'b0, 4'b1000, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{1'b1,1'b1,1'b0,1'b1, 32'h302, 32'h0, 32'h0, 32'h11223344, 4'd7, 1'b1, 0, 1'b0, 4'b0100, 32'h0, 1'b0, 1'b1, 32'h00000022};
    vecs[5]  = '{1'b1,1'b0,1'b1,1'b0, 32'h400, 32'h0BADF00D, 32'h0, 32'h0, 4'd8, 1'b0, 0, 1'b0, 4'hF, 32'h0BADF00D, 1'b1, 1'b0, 32'h0};
    vecs[6]  = '{1'b1,1'b1,1'b0,1'b0, 32'h101, 32'h0, 32'h0, 32'h0, 4'd9, 1'b1, 0, 1'b1, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b1,1'b1,1'b1,1'b0, 32'h500, 32'h55AA55AA, 32'h0, 32'h12345678, 4'd10, 1'b1, 2, 1'b0, 4'hF, 32'h55AA55AA, 1'b1, 1'b0, 32'h0};
    vecs[8]  = '{1'b1,1'b1,1'b0,1'b1, 32'h3, 32'h0, 32'h0, 32'h80FFEE01, 4'd11, 1'b1, 1, 1'b0, 4'b1000, 32'h0, 1'b0, 1'b1, 32'h00000080};
    vecs[9]  = '{1'b0,1'b1,1'b1,1'b0, 32'h700, 32'h0, 32'h77, 32'h0, 4'd7, 1'b1, 0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h77};
    vecs[10] = '{1'b1,1'b1,1'b0,1'b1, 32'h101, 32'h0, 32'h0, 32'hAABBCCDD, 4'd12, 1'b1, 0, 1'b0, 4'b0010, 32'h0, 1'b0, 1'b1, 32'h000000CC};

    // asynchronous reset, checked before any clock edge
    #1 reset = 1'b1;
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_req", dm_req, 1'b0);
    chk("rst_we", dm_we, 1'b0);
    chk("rst_be", dm_be, 4'h0);
    chk("rst_fault", misalign_fault, 1'b0);
    chk("rst_wb_en", wb_rf_enable, 1'b0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_rd", wb_rd, 4'h0);
    chk("rst_addr", dm_addr, 32'h0);
    chk("rst_wdata", dm_wdata, 32'h0);
    tick;
    reset = 1'b0;
    tick;

    for (int i = 0; i < 11; i++) apply(vecs[i]);

    // reset in the middle of a pending access, then a late ack
    drive_idle();
    ex_mem_enable = 1'b1; ex_load = 1'b1; ex_addr = 32'h600; ex_rd = 4'd4; ex_rf_enable = 1'b1;
    tick;
    chk("rr_req", dm_req, 1'b1);
    drive_idle();
    #2 reset = 1'b1;
    #1;
    chk("rr_req_drop", dm_req, 1'b0);
    chk("rr_stall", stall, 1'b0);
    chk("rr_be", dm_be, 4'h0);
    tick;
    reset = 1'b0;
    tick;
    dm_ack = 1'b1;
    dm_rdata = 32'hFEEDFACE;
    #1;
    chk("late_ack_stall", stall, 1'b0);
    tick;
    dm_ack = 1'b0;
    chk("late_ack_wb_en", wb_rf_enable, 1'b0);
    chk("late_ack_req", dm_req, 1'b0);
    chk("late_ack_wb_data", wb_data, 32'h0);

    // the FSM must still be idle: a non-memory op passes straight through
    ex_alu_result = 32'h99; ex_rd = 4'd2; ex_rf_enable = 1'b1;
    #1;
    chk("post_rst_stall", stall, 1'b0);
    tick;
    chk("post_rst_wb_data", wb_data, 32'h99);
    chk("post_rst_wb_en", wb_rf_enable, 1'b1);
    drive_idle();
    tick;

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
